// File: rtl/sort4_lt_engine.sv
// Four-word sequential sorter: odd-even transposition, one compare-swap pass per clock,
// result presented with a valid/ack handshake.
module sort4_lt_engine #(
    parameter int DATAWIDTH = 32
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 start,
    input  logic                 dir,
    input  logic [DATAWIDTH-1:0] a0,
    input  logic [DATAWIDTH-1:0] a1,
    input  logic [DATAWIDTH-1:0] a2,
    input  logic [DATAWIDTH-1:0] a3,
    input  logic                 ack,
    output logic [DATAWIDTH-1:0] s0,
    output logic [DATAWIDTH-1:0] s1,
    output logic [DATAWIDTH-1:0] s2,
    output logic [DATAWIDTH-1:0] s3,
    output logic                 out_valid,
    output logic                 busy
);

    // state | meaning
    // IDLE  | waiting for start, words may be loaded
    // SORT  | one compare-swap pass per clock, 4 passes
    // DONE  | result held, waiting for ack
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATAWIDTH-1:0] r0, r1, r2, r3;
    logic [DATAWIDTH-1:0] n0, n1, n2, n3;
    logic                 dir_q;
    logic [1:0]           pass_cnt;
    logic                 swap01, swap12, swap23;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SORT;
            SORT: if (pass_cnt == 2'd3) state_nxt = DONE;
            DONE: if (ack) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Strict compares: equal words never swap.
    always_comb begin
        swap01 = dir_q ? (r1 > r0) : (r1 < r0);
        swap12 = dir_q ? (r2 > r1) : (r2 < r1);
        swap23 = dir_q ? (r3 > r2) : (r3 < r2);
    end

    always_comb begin
        n0 = r0;
        n1 = r1;
        n2 = r2;
        n3 = r3;
        if (!pass_cnt[0]) begin
            if (swap01) begin
                n0 = r1;
                n1 = r0;
            end
            if (swap23) begin
                n2 = r3;
                n3 = r2;
            end
        end else if (swap12) begin
            n1 = r2;
            n2 = r1;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r0       <= '0;
            r1       <= '0;
            r2       <= '0;
            r3       <= '0;
            dir_q    <= 1'b0;
            pass_cnt <= 2'd0;
        end else if (state == IDLE && start) begin
            r0       <= a0;
            r1       <= a1;
            r2       <= a2;
            r3       <= a3;
            dir_q    <= dir;
            pass_cnt <= 2'd0;
        end else if (state == SORT) begin
            r0       <= n0;
            r1       <= n1;
            r2       <= n2;
            r3       <= n3;
            pass_cnt <= pass_cnt + 2'd1;
        end
    end

    always_comb begin
        s0 = r0;
        s1 = r1;
        s2 = r2;
        s3 = r3;
    end

endmodule

// File: tb/tb_sort4_lt_engine.sv
// Directed bench for sort4_lt_engine: hand-computed sorted results, latency and handshake checks.
module tb_sort4_lt_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, dir, ack;
    logic [31:0] a0, a1, a2, a3;
    logic [31:0] s0, s1, s2, s3;
    logic        out_valid, busy;

    int n_cmp = 0;
    int n_err = 0;
    int k;

    sort4_lt_engine #(.DATAWIDTH(32)) dut (
        .Clk(clk), .Rst(rst), .start(start), .dir(dir),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .ack(ack),
        .s0(s0), .s1(s1), .s2(s2), .s3(s3),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_s(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
        chk({tag, "_s0"}, s0, e0);
        chk({tag, "_s1"}, s1, e1);
        chk({tag, "_s2"}, s2, e2);
        chk({tag, "_s3"}, s3, e3);
    endtask

    // Drives start for exactly one edge; returns at the falling edge after that edge.
    task automatic start_sort(input logic d, input logic [31:0] x0, input logic [31:0] x1,
                              input logic [31:0] x2, input logic [31:0] x3);
        start = 1'b1; dir = d;
        a0 = x0; a1 = x1; a2 = x2; a3 = x3;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts falling edges until out_valid is seen, bounded.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 12) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; dir = 1'b0; ack = 1'b0;
        a0 = '0; a1 = '0; a2 = '0; a3 = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Idle with no start: everything stays at reset values.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_valid", {31'd0, out_valid}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
        end
        chk_s("idle", 32'd0, 32'd0, 32'd0, 32'd0);

        // Ascending sort, latency 4, result held without ack.
        start_sort(1'b0, 32'd7, 32'd3, 32'd9, 32'd1);
        chk("asc_busy", {31'd0, busy}, 32'd1);
        wait_valid(k);
        chk("asc_latency", k, 32'd4);
        chk_s("asc", 32'd1, 32'd3, 32'd7, 32'd9);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("asc_hold_valid", {31'd0, out_valid}, 32'd1);
            chk("asc_hold_s0", s0, 32'd1);
        end
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("asc_ack_valid", {31'd0, out_valid}, 32'd0);
        chk("asc_ack_busy", {31'd0, busy}, 32'd0);

        // Descending with extremes and duplicates.
        start_sort(1'b1, 32'd0, 32'hFFFF_FFFF, 32'd5, 32'd5);
        wait_valid(k);
        chk("desc_latency", k, 32'd4);
        chk_s("desc", 32'hFFFF_FFFF, 32'd5, 32'd5, 32'd0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // Start and input changes while sorting are ignored.
        start_sort(1'b0, 32'd20, 32'd10, 32'd40, 32'd30);
        start = 1'b1; dir = 1'b1;
        a0 = 32'd100; a1 = 32'd100; a2 = 32'd100; a3 = 32'd100;
        wait_valid(k);
        chk("ignore_latency", k, 32'd4);
        chk_s("ignore", 32'd10, 32'd20, 32'd30, 32'd40);
        start = 1'b0;
        @(negedge clk);
        chk("ignore_hold_valid", {31'd0, out_valid}, 32'd1);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;

        // Asynchronous reset during pass 2 discards the sort.
        start_sort(1'b0, 32'd9, 32'd8, 32'd7, 32'd6);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk_s("rst", 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_no_done", {31'd0, out_valid}, 32'd0);
        chk("rst_idle", {31'd0, busy}, 32'd0);

        start_sort(1'b0, 32'd4, 32'd2, 32'd3, 32'd1);
        wait_valid(k);
        chk("post_rst_latency", k, 32'd4);
        chk_s("post_rst", 32'd1, 32'd2, 32'd3, 32'd4);

        // Start together with ack in DONE: back to IDLE, no new sort.
        start = 1'b1; ack = 1'b1;
        @(negedge clk);
        start = 1'b0; ack = 1'b0;
        chk("sa_valid", {31'd0, out_valid}, 32'd0);
        chk("sa_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        chk("sa_no_sort", {31'd0, busy}, 32'd0);

        // Back-to-back with start and ack held: busy 5 cycles, idle 1 cycle, per sort.
        dir = 1'b0; a0 = 32'd3; a1 = 32'd1; a2 = 32'd2; a3 = 32'd0;
        start = 1'b1; ack = 1'b1;
        for (int n = 0; n < 2; n++) begin
            k = 0;
            while (!busy && k < 12) begin
                @(negedge clk);
                k++;
            end
            if (n > 0) chk("b2b_idle_gap", k, 32'd1);
            k = 0;
            while (busy && k < 12) begin
                if (out_valid) chk_s("b2b", 32'd0, 32'd1, 32'd2, 32'd3);
                @(negedge clk);
                k++;
            end
            chk("b2b_busy_len", k, 32'd5);
        end
        start = 1'b0; ack = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
